// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : Parametrised pipelined WIDTH-bit adder/subtractor. The carry
//             chain is cut into STAGES equal slices with one register stage
//             per slice. A valid/ready handshake on both sides allows one
//             operation per cycle and a clean stall under back-pressure.
//
//  Parameters
//    WIDTH      operand/result width, must be a multiple of STAGES
//    STAGES     number of pipeline stages (>= 1)
//
//  Ports
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   operand set on a/b/cin/sub is valid
//    in_ready   operand set is accepted on this edge (= advance enable)
//    a, b       operands (unsigned or two's complement)
//    cin        carry-in, ignored when sub = 1
//    sub        0: a + b + cin, 1: a - b
//    out_valid  sum/cout (and flags) hold a result
//    out_ready  consumer takes the result on this edge
//    sum        result, mod 2^WIDTH
//    cout       carry out of the MSB (subtract: 1 = no borrow)
//    zero, neg, ovf   status flags, only when PIPE_ADDER_FLAGS_EN is defined
//
//  Build option
//    PIPE_ADDER_FLAGS_EN  adds registered zero/neg/ovf outputs aligned with
//                         sum. Undefined by default.
//
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    // Bits resolved by each stage.
    localparam int c_SW = WIDTH / STAGES;

    // ------------------------------------------------------------------
    // Handshake. The whole pipe moves as one: it advances whenever the
    // output register is empty or being drained. in_ready depends only on
    // the output side, never on in_valid, so no combinational loop can
    // form through an upstream producer.
    // ------------------------------------------------------------------
    logic             w_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign w_accept  = in_valid && w_adv;

    // Subtraction as a + ~b + 1; the user carry-in is ignored in that mode.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;

    // ------------------------------------------------------------------
    // Stage k adds slice k of the operands with the carry registered by
    // stage k-1. After stage k, bits [(k+1)*c_SW-1:0] of the sum are
    // known and carried forward; the not-yet-consumed upper operand bits
    // travel alongside in skew registers so every slice meets its carry
    // in the right cycle.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_LO = k * c_SW;        // first bit handled here
        localparam int c_HI = (k + 1) * c_SW;  // bits known after this stage

        logic [c_SW-1:0] w_a_sl;
        logic [c_SW-1:0] w_b_sl;
        logic            w_c_in;
        logic            w_v_in;
        logic [c_SW:0]   w_add;
        logic [c_HI-1:0] w_sum_nxt;

        logic [c_HI-1:0] r_sum;
        logic            r_carry;
        logic            r_valid;

        if (k == 0) begin : g_head
            // First slice takes its operands straight from the ports.
            assign w_a_sl    = a[c_SW-1:0];
            assign w_b_sl    = w_b_eff[c_SW-1:0];
            assign w_c_in    = w_cin_eff;
            assign w_v_in    = w_accept;
            assign w_sum_nxt = w_add[c_SW-1:0];
        end else begin : g_body
            // Later slices take operands from the previous skew register
            // and append their result above the already-resolved bits.
            assign w_a_sl    = g_stage[k-1].g_skew.r_a[c_LO +: c_SW];
            assign w_b_sl    = g_stage[k-1].g_skew.r_b[c_LO +: c_SW];
            assign w_c_in    = g_stage[k-1].r_carry;
            assign w_v_in    = g_stage[k-1].r_valid;
            assign w_sum_nxt = {w_add[c_SW-1:0], g_stage[k-1].r_sum};
        end

        // One slice of ripple: the only arithmetic between registers.
        assign w_add = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{c_SW{1'b0}}, w_c_in};

        // Data moves together with its valid bit; a bubble entering a stage
        // just carries valid = 0, its data content is don't-care.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_sum   <= w_sum_nxt;
                r_carry <= w_add[c_SW];
                r_valid <= w_v_in;
            end
        end

        // Skew registers for the operand bits still to be added. The final
        // stage has none left, so it has no skew register at all.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:c_HI] w_a_up;
            logic [WIDTH-1:c_HI] w_b_up;
            logic [WIDTH-1:c_HI] r_a;
            logic [WIDTH-1:c_HI] r_b;

            if (k == 0) begin : g_src_port
                assign w_a_up = a[WIDTH-1:c_HI];
                assign w_b_up = w_b_eff[WIDTH-1:c_HI];
            end else begin : g_src_prev
                assign w_a_up = g_stage[k-1].g_skew.r_a[WIDTH-1:c_HI];
                assign w_b_up = g_stage[k-1].g_skew.r_b[WIDTH-1:c_HI];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

`ifdef PIPE_ADDER_FLAGS_EN
        // Flags are computed from the final stage's adder inputs and
        // registered together with the sum, so they stay aligned with it.
        if (k == STAGES - 1) begin : g_flags
            logic w_msb_cin;
            logic r_zero;
            logic r_neg;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB's own sum bit.
            assign w_msb_cin = w_a_sl[c_SW-1] ^ w_b_sl[c_SW-1] ^ w_add[c_SW-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_zero <= 1'b0;
                    r_neg  <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_adv) begin
                    r_zero <= (w_sum_nxt == '0);
                    r_neg  <= w_sum_nxt[c_HI-1];
                    r_ovf  <= w_msb_cin ^ w_add[c_SW];
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the final stage registers; holding the
    // whole pipe while out_ready is low keeps them stable.
    // ------------------------------------------------------------------
    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;

`ifdef PIPE_ADDER_FLAGS_EN
    assign zero = g_stage[STAGES-1].g_flags.r_zero;
    assign neg  = g_stage[STAGES-1].g_flags.r_neg;
    assign ovf  = g_stage[STAGES-1].g_flags.r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Scoreboard bench for pipelined_adder. Two instances:
//             16-bit / 4 stages and 8-bit / 1 stage. Directed vectors with
//             hand-computed results are pushed on acceptance and popped by a
//             monitor on every output transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [15:0] s;
        logic        c, z, n, o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t cur16, cur8, e16, e8;

    // ---------------- 16-bit, 4-stage instance ----------------
    logic        rst16, in_valid16, in_ready16, cin16, sub16;
    logic        out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef PIPE_ADDER_FLAGS_EN
    logic        zero16, neg16, ovf16;
`endif

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .cout(cout16)
`ifdef PIPE_ADDER_FLAGS_EN
        , .zero(zero16), .neg(neg16), .ovf(ovf16)
`endif
    );

    // ---------------- 8-bit, 1-stage instance ----------------
    logic       rst8, in_valid8, in_ready8, cin8, sub8;
    logic       out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef PIPE_ADDER_FLAGS_EN
    logic       zero8, neg8, ovf8;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_FLAGS_EN
        , .zero(zero8), .neg(neg8), .ovf(ovf8)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitors / scoreboards ----------------
    bit          stall16 = 1'b0;
    logic [15:0] held16;

    always @(negedge clk) begin
        if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                chk("d16_spurious_out", out_valid16, 0);
            end else begin
                e16 = q16.pop_front();
                chk("d16_sum", sum16, e16.s);
                chk("d16_cout", cout16, e16.c);
`ifdef PIPE_ADDER_FLAGS_EN
                chk("d16_zero", zero16, e16.z);
                chk("d16_neg", neg16, e16.n);
                chk("d16_ovf", ovf16, e16.o);
`endif
                if (e16.lat) chk("d16_latency", cyc - e16.acc, 3);
            end
        end
        if (out_valid16 && !out_ready16) begin
            chk("d16_in_ready_stall", in_ready16, 0);
            if (stall16) chk("d16_sum_hold", sum16, held16);
            stall16 = 1'b1;
            held16  = sum16;
        end else begin
            stall16 = 1'b0;
        end
        if (rst16) begin
            q16.delete();
        end else if (in_valid16 && in_ready16) begin
            e16     = cur16;
            e16.acc = cyc + 1;
            q16.push_back(e16);
        end
    end

    always @(negedge clk) begin
        if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("d8_spurious_out", out_valid8, 0);
            end else begin
                e8 = q8.pop_front();
                chk("d8_sum", {8'h00, sum8}, e8.s);
                chk("d8_cout", cout8, e8.c);
`ifdef PIPE_ADDER_FLAGS_EN
                chk("d8_zero", zero8, e8.z);
                chk("d8_neg", neg8, e8.n);
                chk("d8_ovf", ovf8, e8.o);
`endif
                if (e8.lat) chk("d8_latency", cyc - e8.acc, 0);
            end
        end
        if (rst8) begin
            q8.delete();
        end else if (in_valid8 && in_ready8) begin
            e8     = cur8;
            e8.acc = cyc + 1;
            q8.push_back(e8);
        end
    end

    // ---------------- stimulus tasks ----------------
    // Entered and left at posedge+1; holds the operand set until accepted.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic sb, input logic [15:0] es, input logic ec,
                           input logic ez, input logic en, input logic eo, input bit lat);
        int n = 0;
        cur16.s = es; cur16.c = ec; cur16.z = ez; cur16.n = en; cur16.o = eo;
        cur16.acc = 0; cur16.lat = lat;
        a16 = a; b16 = b; cin16 = ci; sub16 = sb; in_valid16 = 1'b1;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("d16_accept", in_ready16, 1);
        @(posedge clk);
        #1 in_valid16 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, input logic [7:0] es, input logic ec,
                          input logic ez, input logic en, input logic eo);
        int n = 0;
        cur8.s = {8'h00, es}; cur8.c = ec; cur8.z = ez; cur8.n = en; cur8.o = eo;
        cur8.acc = 0; cur8.lat = 1'b1;
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; in_valid8 = 1'b1;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("d8_accept", in_ready8, 1);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_drained"}, q16.size() + q8.size(), 0);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst16 = 1'b1; in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        out_ready16 = 1'b1;
        rst8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst16 = 1'b0; rst8 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid16", out_valid16, 0);
        chk("rst_sum16", sum16, 0);
        chk("rst_cout16", cout16, 0);
        chk("rst_in_ready16", in_ready16, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_in_ready8", in_ready8, 1);
`ifdef PIPE_ADDER_FLAGS_EN
        chk("rst_flags16", {zero16, neg16, ovf16}, 0);
        chk("rst_flags8", {zero8, neg8, ovf8}, 0);
`endif
        @(posedge clk);
        #1;

        // Directed vectors, back to back:     a        b      cin sub   sum   c  z  n  o
        issue16(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 1, 0, 0, 1); // carry wrap
        issue16(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 1, 0, 1); // subtract, cin ignored
        issue16(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 0, 1, 1, 1); // signed overflow
        issue16(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0, 0, 1);
        issue16(16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 1, 0, 0, 1); // 0-0: no borrow
        issue16(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 0, 0, 1, 1); // negative overflow
        issue16(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0, 0, 1); // carry across slices
        issue16(16'h0FFF, 16'h0000, 1, 0, 16'h1000, 0, 0, 0, 0, 1); // cin ripples 3 slices
        drain("directed16");

        // Back-pressure: 8 sets a=i, b=i with out_ready low for 3 cycles
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    issue16(16'(i), 16'(i), 0, 0, 16'(2 * i), 0, 0, 0, 0, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready16 = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready16 = 1'b1;
            end
        join
        drain("stream16");

        // Reset with 3 transactions in flight
        issue16(16'h0100, 16'h0001, 0, 0, 16'h0101, 0, 0, 0, 0, 0);
        issue16(16'h0200, 16'h0002, 0, 0, 16'h0202, 0, 0, 0, 0, 0);
        issue16(16'h0300, 16'h0003, 0, 0, 16'h0303, 0, 0, 0, 0, 0);
        rst16 = 1'b1;
        @(posedge clk);
        #1 rst16 = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid16, 0);
        chk("midrst_sum", sum16, 0);
        chk("midrst_in_ready", in_ready16, 1);
        repeat (6) @(posedge clk);
        #1;
        issue16(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 0, 0, 1);
        drain("postrst16");

        // Single-stage instance:   a      b   cin sub  sum  c  z  n  o
        issue8(8'h80, 8'h80, 0, 0, 8'h00, 1, 1, 0, 1);
        issue8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 0, 1, 1);
        issue8(8'h10, 8'h20, 1, 1, 8'hF0, 0, 0, 1, 0);
        issue8(8'h3C, 8'hC3, 1, 0, 8'h00, 1, 1, 0, 0);
        drain("single8");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor for the processor datapath. The carry chain is split into `STAGES` equal slices, with one register stage per slice. A valid/ready handshake on both sides lets the ALU issue one operation per cycle and stall cleanly when the consumer is busy. Operand skew buffers keep results in order, and an optional status-flag output feeds the condition-code logic.

## Interface
- `WIDTH`, 16: operand and result width in bits. Must be a multiple of `STAGES`.
- `STAGES`, 4: number of pipeline stages, ≥1. Each stage resolves `WIDTH/STAGES` bits of the sum.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand set on `a`, `b`, `cin`, `sub` is valid.
- `in_ready` output 1: the block accepts an operand set on this edge.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in. Ignored when `sub`=1.
- `sub` input 1: 0 computes a+b+cin; 1 computes a−b.
- `out_valid` output 1: `sum`/`cout` (and flags) hold a result.
- `out_ready` input 1: the consumer takes the result on this edge.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `zero`, `neg`, `ovf` outputs, 1 each: status flags, present only with `PIPE_ADDER_FLAGS_EN`.

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready` at a rising edge. An output transfer occurs when `out_valid && out_ready`.
- **Subtract mode.** `sub`=1 uses ~b as the B operand and forces the carry-in to 1. This is pure two's-complement arithmetic, mod 2^WIDTH.
- **Stage k** (0..STAGES−1):
  - Adds slice k of A and B′ with the carry registered by stage k−1. Stage 0 uses the effective carry-in.
  - Registers the partial sum slice, its carry, and a valid bit.
- **Skew buffers.** Upper operand slices are carried forward in skew registers. Lower sum slices are carried forward alongside, so the final stage presents a complete, aligned `sum`.
- **Stall and advance.**
  - Global advance enable = `!out_valid || out_ready`, and `in_ready` equals this enable.
  - When the enable is low, every stage holds, including bubbles.
  - When the enable is high, all stages shift by one. A stage that receives no input transfer loads valid=0.
- **Ordering.** Results emerge in acceptance order, with no loss and no duplication.
- **Output stability.** While `out_valid && !out_ready`, `sum`, `cout` and the flags are held stable.
- **`cin` in subtract mode.** `cin` has no effect when `sub`=1.

## Timing
- **Reset.** `rst` high at an edge:
  - Clears all valid bits, skew and data registers.
  - Drives `out_valid`=0, `sum`=0, `cout`=0 and all flags=0 from the next cycle.
  - `in_ready` is 1 after reset, because `out_valid`=0.
  - Reset mid-operation discards every in-flight transaction. Reset takes priority over any simultaneous transfer.
- **Latency.** A set accepted at edge E appears with `out_valid`=1 immediately after edge E+STAGES−1, i.e. STAGES edges including E. With `STAGES`=1 the result is valid the cycle after acceptance.
- **Throughput.** One result per cycle while `out_ready`=1.
- **Simultaneous transfers.** An output transfer and an input transfer on the same edge are both taken. The pipeline stays full.
- **`in_ready` path.** `in_ready` is combinational from `out_valid` and `out_ready` only. It never depends on `in_valid`.
- **Critical path.** One slice ripple of `WIDTH/STAGES` bits plus register setup.

## Configuration
- **`PIPE_ADDER_FLAGS_EN` defined:** the `zero`, `neg` and `ovf` ports exist, are registered in the final stage, and are aligned with `sum`.
  - `zero` = (sum==0).
  - `neg` = sum[WIDTH−1].
  - `ovf` = carry into MSB XOR `cout` (signed overflow).
- **`PIPE_ADDER_FLAGS_EN` undefined:** the ports and their logic are absent. The remaining behaviour is identical.

## Test plan
- **Carry wrap.** WIDTH=16, STAGES=4, a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, zero=1, with `out_valid` rising after the 4th edge counting the accept edge.
- **Subtract.** a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, neg=1, ovf=0.
- **Signed overflow.** a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, neg=1, cout=0.
- **Back-pressure.** Stream 8 sets a=i, b=i (i=1..8) with `out_ready` held low for 3 cycles mid-stream -> outputs are exactly 2,4,…,16 in order, `in_ready` is low while stalled with a full output, and `sum` is stable during the stall.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 transactions in flight -> `out_valid`=0 next cycle, no stale result ever appears, and a new set accepted afterwards returns the correct value at normal latency.
- **Single stage.** WIDTH=8, STAGES=1, a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1, valid one cycle after acceptance.
